fanout_fork_buffer: RTL
=======================

Name: fanout_fork_buffer

Overview:
- Registered 2-entry fork buffer.
- Sits directly upstream of a hierarchical high-fanout load cluster.
- Takes one valid/ready input stream and broadcasts each word to NUM_LOADS independent consumer branches, each with its own handshake.
- Retires a word only after every branch has accepted it, so a slow branch stalls the source and the other branches never see duplicates.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- NUM_LOADS, 3, number of consumer branches (2..16).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  source has a word on in_data.
- in_ready  output  1  buffer can accept a word this cycle.
- in_data  input  WIDTH  source word.
- out_valid  output  NUM_LOADS  bit i: head word pending for branch i.
- out_ready  input  NUM_LOADS  bit i: branch i accepts this cycle.
- out_data  output  WIDTH  head word, shared by all branches.
- pending  output  NUM_LOADS  bit i: branch i has not yet taken the head word (equals out_valid).
- occupancy  output  2  number of stored words, 0..2.

Behaviour:
- Storage:
  - Two WIDTH-bit entries, wr_ptr and rd_ptr (1 bit each), count (0..2).
  - A per-branch done mask, done[NUM_LOADS].
- Reset (rst_n low at a clock edge):
  - count=0, wr_ptr=rd_ptr=0, done=0.
  - Entry contents are don't-care.
  - Outputs after that edge: out_valid=0, pending=0, occupancy=0, out_data=entry[0] (don't-care).
  - in_ready=0 while rst_n is low; in_ready=1 on the first cycle after rst_n goes high.
  - Reset mid-transfer discards both stored words and the partial done mask, with no further out_valid for them.
- in_ready = rst_n & (count != 2).
  - Purely a function of registered state; no combinational path from out_ready.
- Push: in_valid & in_ready. Write entry[wr_ptr], toggle wr_ptr.
- Head valid: hv = (count != 0).
- Per branch i:
  - out_valid[i] = hv & ~done[i].
  - Branch fire f[i] = out_valid[i] & out_ready[i].
- Complete: all_taken = hv & &(done | f).
- Pop:
  - When all_taken holds, toggle rd_ptr and clear done to 0.
  - Otherwise done <= done | f.
- count update:
  - count+1 on push only.
  - count-1 on pop only.
  - Unchanged on push and pop together.
  - With count=2, in_ready=0, so a same-cycle pop does not enable a push; the push is accepted the following cycle. This is intended (no full bypass).
- Latency:
  - A word accepted at edge t is presented (out_valid high) from cycle t+1.
  - No input-to-output combinational path.
- Throughput: one word per cycle sustained when all out_ready are held high (count stays at 1).
- Ordering: strict FIFO order, identical for every branch.
- Each word is delivered exactly once to each branch.
- A branch that already took the head sees out_valid[i]=0 until the next word becomes head (earliest the cycle after the pop).
- out_ready[i] while out_valid[i]=0 is ignored.
- out_data = entry[rd_ptr]; stable while hv and no pop.
- occupancy = count.
- Protocol assumption on the source: in_data is held stable while in_valid & ~in_ready. The block does not check this.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n=0 for 2 cycles, then rst_n=1, in_valid=0.
  - Response: out_valid=0, occupancy=0, in_ready=0 during reset and 1 after.
- Single word, all branches ready:
  - Stimulus: push 0xA5 at cycle 5 with out_ready=3'b111.
  - Response: out_valid=3'b111 and out_data=0xA5 in cycle 6, occupancy=0 in cycle 7.
- Staggered acceptance:
  - Stimulus: push 0x11; out_ready=001, then 100, then 010 in successive cycles.
  - Response: out_valid goes 111, 110, 010, then 000; the pop happens on the third accept; no branch sees 0x11 twice.
- Backpressure to full:
  - Stimulus: out_ready=0; push 0x01, 0x02, 0x03 back to back.
  - Response: occupancy reaches 2 and in_ready=0 with 0x03 held at the source; 0x03 is accepted one cycle after the first pop; the branches see 0x01, 0x02, 0x03 in order.
- Streaming:
  - Stimulus: in_valid=1 with 20 incrementing words 0x00..0x13, out_ready=111 held.
  - Response: one word per cycle on out_data, occupancy stays 1, the last word appears 1 cycle after its push.
- Reset mid-operation:
  - Stimulus: occupancy=2 with done=010, then assert rst_n=0 for 1 cycle.
  - Response: out_valid=0, occupancy=0, done cleared; the next push 0x7E is delivered to all three branches.

Source files
------------

// File: rtl/fanout_fork_buffer.sv
// Two-entry registered fork buffer: each accepted word is broadcast to NUM_LOADS
// branches and retired only once every branch has taken it.
module fanout_fork_buffer #(
    parameter int WIDTH     = 8,
    parameter int NUM_LOADS = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic [NUM_LOADS-1:0] out_valid,
    input  logic [NUM_LOADS-1:0] out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [NUM_LOADS-1:0] pending,
    output logic [1:0]           occupancy
);

    logic [WIDTH-1:0]     entry [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    logic [NUM_LOADS-1:0] done;

    logic                 push;
    logic                 pop;
    logic                 hv;
    logic [NUM_LOADS-1:0] fire;

    // No full bypass: a pop while full does not open in_ready in the same cycle.
    assign in_ready  = rst_n & (count != 2'd2);
    assign push      = in_valid & in_ready;
    assign hv        = (count != 2'd0);
    assign out_valid = {NUM_LOADS{hv}} & ~done;
    assign fire      = out_valid & out_ready;
    assign pop       = hv & (&(done | fire));
    assign pending   = out_valid;
    assign out_data  = entry[rd_ptr];
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            done   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                done   <= '0;
            end else begin
                done   <= done | fire;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; contents are only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            entry[wr_ptr] <= in_data;
        end
    end

endmodule
